// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one in-order memory bus between instruction fetch
// (ibus) and the data port (dbus), routing each response back to its requester.
module mem_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ibus_req_valid,
  output logic              ibus_req_ready,
  input  logic [XLEN-1:0]   ibus_req_addr,
  output logic              ibus_rsp_valid,
  output logic [XLEN-1:0]   ibus_rsp_rdata,
  input  logic              ibus_flush,

  input  logic              dbus_req_valid,
  output logic              dbus_req_ready,
  input  logic              dbus_req_write,
  input  logic [XLEN-1:0]   dbus_req_addr,
  input  logic [XLEN-1:0]   dbus_req_wdata,
  input  logic [XLEN/8-1:0] dbus_req_wstrb,
  output logic              dbus_rsp_valid,
  output logic [XLEN-1:0]   dbus_rsp_rdata,

  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rsp_rdata
);

  localparam int STRB_W   = XLEN / 8;
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {
    SRC_DBUS = 1'b0,
    SRC_IBUS = 1'b1
  } src_e;

  // Arbitration state
  logic                r_lock_valid;
  src_e                r_lock_src;
  logic [STARVE_W-1:0] r_starve_cnt;

  // Outstanding-transaction tracker
  src_e                r_src  [MAX_OUTSTANDING];
  logic                r_drop [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  src_e                w_grant_src;
  logic                w_grant_valid;
  logic                w_starved;
  logic                w_full;
  logic                w_empty;
  logic                w_slot_ready;
  logic                w_bus_req_valid;
  logic                w_push;
  logic                w_pop;
  src_e                w_head_src;
  logic                w_head_drop;

  assign w_full    = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty   = (r_count == '0);
  assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

  // A stalled request keeps its owner so the bus sees a stable request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_grant_src = SRC_IBUS;
    if (r_lock_valid) begin
      w_grant_src = r_lock_src;
    end else if (w_starved && ibus_req_valid) begin
      w_grant_src = SRC_IBUS;
    end else if (dbus_req_valid) begin
      w_grant_src = SRC_DBUS;
    end
  end

  assign w_grant_valid   = (w_grant_src == SRC_DBUS) ? dbus_req_valid : ibus_req_valid;
  assign w_bus_req_valid = w_grant_valid & ~w_full & ~rst;
  assign w_slot_ready    = bus_req_ready & ~w_full & ~rst;
  assign w_push          = w_bus_req_valid & bus_req_ready;

  assign bus_req_valid   = w_bus_req_valid;
  assign ibus_req_ready  = w_slot_ready & (w_grant_src == SRC_IBUS);
  assign dbus_req_ready  = w_slot_ready & (w_grant_src == SRC_DBUS);

  // Fetches are always plain reads with no strobes or data.
  always_comb begin
    bus_req_write = 1'b0;
    bus_req_addr  = ibus_req_addr;
    bus_req_wdata = '0;
    bus_req_wstrb = '0;
    if (w_grant_src == SRC_DBUS) begin
      bus_req_write = dbus_req_write;
      bus_req_addr  = dbus_req_addr;
      bus_req_wdata = dbus_req_wdata;
      bus_req_wstrb = dbus_req_wstrb;
    end
  end

  // A response with nothing outstanding is ignored entirely.
  assign w_pop       = bus_rsp_valid & ~w_empty & ~rst;
  assign w_head_src  = r_src[r_rd_ptr];
  assign w_head_drop = r_drop[r_rd_ptr];

  assign dbus_rsp_valid = w_pop & (w_head_src == SRC_DBUS);
  assign ibus_rsp_valid = w_pop & (w_head_src == SRC_IBUS) & ~w_head_drop & ~ibus_flush;
  assign ibus_rsp_rdata = bus_rsp_rdata;
  assign dbus_rsp_rdata = bus_rsp_rdata;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_lock_valid <= 1'b0;
      r_lock_src   <= SRC_DBUS;
      r_starve_cnt <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_lock_valid <= w_bus_req_valid & ~bus_req_ready;
      if (w_bus_req_valid && !bus_req_ready) begin
        r_lock_src <= w_grant_src;
      end

      if (!ibus_req_valid || (w_push && w_grant_src == SRC_IBUS)) begin
        r_starve_cnt <= '0;
      end else if (w_push && w_grant_src == SRC_DBUS && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // Full check above used the pre-pop count, so push+pop when full never overflows.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A flush marks every fetch slot, including the one written this cycle;
  // stale slots are harmless because a push rewrites both fields.
  always_ff @(posedge clk) begin
    // NOTE: tracker storage is not reset; the count and pointers alone define which slots are live.
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (ibus_flush && r_src[i] == SRC_IBUS) begin
        r_drop[i] <= 1'b1;
      end
    end
    if (w_push) begin
      r_src[r_wr_ptr]  <= w_grant_src;
      r_drop[r_wr_ptr] <= ibus_flush & (w_grant_src == SRC_IBUS);
    end
  end

  a_rsp_with_empty_tracker: assert property (
    @(posedge clk) disable iff (rst) !(bus_rsp_valid && w_empty)
  ) else $warning("bus response arrived with no outstanding transaction");

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(w_push && w_full)
  );

  a_strb_width: assert property (
    @(posedge clk) $bits(bus_req_wstrb) == STRB_W
  );

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between instruction fetch (ibus, read-only) and the MEM stage data port (dbus).
- Fixed priority goes to dbus, with a starvation guard for ibus.
- Tracks in-order outstanding transactions so each response returns to its requester.
- On a pipeline flush, drops responses for instruction fetches that are still in flight.

Parameters:
- XLEN, 32, data/address width.
- MAX_OUTSTANDING, 4, depth of the outstanding-transaction tracker (power of 2, >=2).
- STARVE_LIMIT, 3, consecutive dbus wins allowed while ibus waits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ibus_req_valid  input  1  fetch request
- ibus_req_ready  output  1  fetch request accepted
- ibus_req_addr  input  XLEN  fetch address
- ibus_rsp_valid  output  1  fetch response
- ibus_rsp_rdata  output  XLEN  fetch data
- ibus_flush  input  1  drop all in-flight fetch responses
- dbus_req_valid  input  1  data request
- dbus_req_ready  output  1  data request accepted
- dbus_req_write  input  1  1 = store, 0 = load
- dbus_req_addr  input  XLEN  data address
- dbus_req_wdata  input  XLEN  store data
- dbus_req_wstrb  input  XLEN/8  byte strobes
- dbus_rsp_valid  output  1  data response
- dbus_rsp_rdata  output  XLEN  load data
- bus_req_valid  output  1  request to memory
- bus_req_ready  input  1  memory accepts request
- bus_req_write  output  1  store flag
- bus_req_addr  output  XLEN  address
- bus_req_wdata  output  XLEN  store data
- bus_req_wstrb  output  XLEN/8  strobes (0 for fetch)
- bus_rsp_valid  input  1  memory response, in request order
- bus_rsp_rdata  input  XLEN  response data

Behaviour:
- Reset: tracker empty, starve_cnt=0, lock clear.
  - While rst=1: bus_req_valid=0, both req_ready=0, both rsp_valid=0.
- Request protocol:
  - valid/ready handshake.
  - Requesters hold valid and payload stable until accepted, including ibus across a flush.
  - Every accepted request, read or write, produces exactly one bus response.
  - Responses return in order, at the earliest one cycle after acceptance.
- Grant selection (combinational), when no lock is held:
  - If starve_cnt==STARVE_LIMIT and ibus_req_valid: grant ibus.
  - Otherwise dbus if valid, otherwise ibus.
- Lock:
  - If bus_req_valid=1 and bus_req_ready=0, the grant owner is registered into lock.
  - The same source is granted until accepted, so the bus request is stable.
  - Lock clears on acceptance.
- Request path:
  - bus_req_valid = granted requester valid & ~tracker_full.
  - Payload is muxed from the grant; fetch forces write=0, wstrb=0, wdata=0.
  - granted_req_ready = bus_req_ready & ~tracker_full; the non-granted ready is 0.
  - Zero-cycle combinational path.
- Tracker: FIFO of {src, drop} entries, MAX_OUTSTANDING deep.
  - Push on bus acceptance; pop on bus_rsp_valid.
  - Simultaneous push and pop is allowed, including when full: the full check uses the pre-pop count, so a full tracker blocks acceptance even if a pop occurs that cycle.
  - Wrap-around uses log2 pointers plus a count.
- Response routing (combinational):
  - Head src=dbus: dbus_rsp_valid=bus_rsp_valid.
  - Head src=ibus and drop=0 and ibus_flush=0: ibus_rsp_valid=bus_rsp_valid.
  - Both rsp_rdata = bus_rsp_rdata, unconditionally.
- Flush (ibus_flush=1):
  - Sets drop on every valid ibus entry, including one pushed in the same cycle.
  - Suppresses ibus_rsp_valid for a head popped in that cycle.
  - dbus entries are unaffected.
  - Dropped entries still pop normally.
- bus_rsp_valid with an empty tracker is a protocol violation: ignored, no rsp_valid, pointers unchanged (flagged by an assertion).
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle ibus_req_valid=1 and a dbus request is accepted.
  - Clears when an ibus request is accepted or ibus_req_valid=0.
  - Holds otherwise.
- Reset mid-operation: all in-flight entries are discarded; responses arriving after reset is released are treated as empty-tracker violations.

Test Plan:
- Both requesters valid continuously, bus_req_ready=1, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; starve_cnt returns to 0 after each I.
- Bus_req_ready=0 for 3 cycles with ibus granted, then dbus_req_valid rises -> ibus stays granted with stable addr; accepted on the ready cycle; dbus follows next.
- 4 fetches issued, bus_req_ready=1, no responses -> 5th request sees ready=0. A response and a new request in the same cycle -> that request is still blocked (pre-pop full); the next cycle it is accepted.
- Fetches A,B outstanding, dbus load C queued, ibus_flush pulsed -> A and B responses produce no ibus_rsp_valid; C's response sets dbus_rsp_valid with rdata 0x1234_5678.
- Flush coincident with acceptance of fetch D and with a head-fetch response -> neither the popped response nor D's later response is delivered.
- rst asserted with 2 entries outstanding -> all outputs go to reset values; a subsequent bus_rsp_valid yields no rsp_valid on either port.
